// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, frame buffer geometry and pixel type
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_ADDR_W = 17;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel tick divider, h/v counters and raw visible/sync flags
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       visible,
    output logic       hs_raw,
    output logic       vs_raw
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;

    assign tick = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) begin
                if (h_cnt == 10'(H_TOTAL - 1)) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    assign visible = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    assign hs_raw  = !((h_cnt >= 10'(H_VISIBLE + H_FP)) &&
                       (h_cnt <  10'(H_VISIBLE + H_FP + H_SYNC)));
    assign vs_raw  = !((v_cnt >= 10'(V_VISIBLE + V_FP)) &&
                       (v_cnt <  10'(V_VISIBLE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - 2x-upscaled RGB565 frame buffer reader to 4:4:4 VGA; FB_READER_GRAY_EN selects luminance output
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [FB_ADDR_W-1:0] rAddr,
    output logic                 oe,
    input  logic [15:0]          rData,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 de,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 frame_start
);

    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       visible;
    logic       hs_raw;
    logic       vs_raw;

    vga_timing_gen #(.CLK_DIV(CLK_DIV)) u_timing (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .visible (visible),
        .hs_raw  (hs_raw),
        .vs_raw  (vs_raw)
    );

    // addr = y*320 + x, with y*320 built from two shifts
    logic [FB_ADDR_W-1:0] x_ext;
    logic [FB_ADDR_W-1:0] y_ext;
    logic [FB_ADDR_W-1:0] addr;

    assign x_ext = {8'd0, h_cnt[9:1]};
    assign y_ext = {8'd0, v_cnt[9:1]};
    assign addr  = (y_ext << 8) + (y_ext << 6) + x_ext;

    logic de_p;
    logic hs_p;
    logic vs_p;
    logic fs_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            rAddr <= '0;
            oe    <= 1'b0;
            de_p  <= 1'b0;
            hs_p  <= 1'b1;
            vs_p  <= 1'b1;
            fs_p  <= 1'b0;
        end else begin
            oe <= tick & visible;
            if (tick) begin
                rAddr <= visible ? addr : '0;
                de_p  <= visible;
                hs_p  <= hs_raw;
                vs_p  <= vs_raw;
                fs_p  <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            end
        end
    end

    rgb444_t conv;

`ifdef FB_READER_GRAY_EN
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] y16;

    assign r8  = {rData[15:11], rData[15:13]};
    assign g8  = {rData[10:5],  rData[10:9]};
    assign b8  = {rData[4:0],   rData[4:2]};
    assign y16 = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};

    always_comb begin
        conv   = '0;
        conv.r = y16[15:12];
        conv.g = y16[15:12];
        conv.b = y16[15:12];
    end
`else
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^{rData[11], rData[6:5], rData[0]};

    always_comb begin
        conv   = '0;
        conv.r = rData[15:12];
        conv.g = rData[10:7];
        conv.b = rData[4:1];
    end
`endif

    rgb444_t colour;

    // rData was registered by the buffer one clock after oe, so it is stable by this tick
    always_ff @(posedge clk) begin
        if (reset) begin
            de          <= 1'b0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            colour      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick & fs_p;
            if (tick) begin
                de     <= de_p;
                h_sync <= hs_p;
                v_sync <= vs_p;
                colour <= de_p ? conv : '0;
            end
        end
    end

    assign red   = colour.r;
    assign green = colour.g;
    assign blue  = colour.b;

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - self-checking bench for vga_fb_reader with frame buffer model and scoreboard
module tb_vga_fb_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] rAddr;
    logic        oe;
    logic [15:0] rData;
    logic        h_sync;
    logic        v_sync;
    logic        de;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        frame_start;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] seed = 32'h0;

    typedef struct {
        int          addr;
        logic [15:0] data;
        logic [11:0] rgb;
    } vec_t;

    vec_t tab[6];

    vga_fb_reader #(.CLK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rAddr       (rAddr),
        .oe          (oe),
        .rData       (rData),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .de          (de),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic int hpos(int n);
        return n % 800;
    endfunction

    function automatic int vpos(int n);
        return (n / 800) % 525;
    endfunction

    function automatic bit vis(int n);
        return (hpos(n) < 640) && (vpos(n) < 480);
    endfunction

    function automatic int addr_of(int n);
        return (vpos(n) / 2) * 320 + hpos(n) / 2;
    endfunction

    function automatic logic [15:0] pix(int a);
        logic [31:0] h;
        if (a < 6) return tab[a].data;
        h = (32'(a) * 32'h9E3779B1) ^ seed;
        return h[23:8];
    endfunction

    function automatic logic [11:0] conv(logic [15:0] d);
`ifdef FB_READER_GRAY_EN
        int r5, g6, b5, r8, g8, b8, y;
        logic [3:0] y4;
        r5 = int'(d[15:11]);
        g6 = int'(d[10:5]);
        b5 = int'(d[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
        y4 = 4'(y / 16);
        return {y4, y4, y4};
`else
        return {d[15:12], d[10:7], d[4:1]};
`endif
    endfunction

    // frame buffer: registers on oe; forced to FFFF while stage 1 holds a blank slot
    always @(posedge clk) begin
        int nxt;
        int t;
        nxt = reset ? 0 : cyc + 1;
        t   = nxt / 4;
        cyc <= nxt;
        if (oe === 1'b1)
            rData <= pix(int'(rAddr));
        else if (t < 1 || !vis(t - 1))
            rData <= 16'hFFFF;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        int t;
        bit v1, v2, hs, vs, fs;
        logic [11:0] c;
        t  = cyc / 4;
        v1 = (t >= 1) && vis(t - 1);
        v2 = (t >= 2) && vis(t - 2);
        hs = 1'b1;
        vs = 1'b1;
        fs = 1'b0;
        c  = 12'h000;
        if (t >= 2) begin
            hs = !(hpos(t - 2) >= 656 && hpos(t - 2) < 752);
            vs = !(vpos(t - 2) >= 490 && vpos(t - 2) < 492);
            fs = (cyc % 4 == 0) && ((t - 2) % 420000 == 0);
            if (v2) c = conv(pix(addr_of(t - 2)));
        end
        chk("oe", oe, (cyc % 4 == 0) && v1);
        chk("rAddr", rAddr, v1 ? addr_of(t - 1) : 0);
        chk("de", de, v2);
        chk("h_sync", h_sync, hs);
        chk("v_sync", v_sync, vs);
        chk("rgb", {red, green, blue}, c);
        chk("frame_start", frame_start, fs);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic run_to(int target);
        int g;
        g = 0;
        while (cyc < target && g < 200000) begin
            step();
            g++;
        end
        chk("run_to", cyc, target);
    endtask

    task automatic check_reset_state();
        chk("rst_oe", oe, 0);
        chk("rst_rAddr", rAddr, 0);
        chk("rst_de", de, 0);
        chk("rst_h_sync", h_sync, 1);
        chk("rst_v_sync", v_sync, 1);
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_frame_start", frame_start, 0);
    endtask

    initial begin
        int lows;
        int first_low;
        int hold;

        seed = $urandom;
`ifdef FB_READER_GRAY_EN
        tab[0] = '{0, 16'hF800, 12'h444};
        tab[1] = '{1, 16'h07E0, 12'h999};
        tab[2] = '{2, 16'h001F, 12'h111};
        tab[3] = '{3, 16'hFFFF, 12'hFFF};
        tab[4] = '{4, 16'h0000, 12'h000};
        tab[5] = '{5, 16'h1234, 12'h333};
`else
        tab[0] = '{0, 16'hF800, 12'hF00};
        tab[1] = '{1, 16'h07E0, 12'h0F0};
        tab[2] = '{2, 16'h001F, 12'h00F};
        tab[3] = '{3, 16'hFFFF, 12'hFFF};
        tab[4] = '{4, 16'h0000, 12'h000};
        tab[5] = '{5, 16'h1234, 12'h1A4 ^ 12'h0EE ^ 12'h0EE};
        tab[5].rgb = {4'h1, 4'h4, 4'hA};
`endif

        reset = 1'b1;
        repeat (5) step();
        check_reset_state();
        reset = 1'b0;

        run_to(3);
        chk("no_early_oe", oe, 0);
        run_to(4);
        chk("first_oe", oe, 1);
        chk("first_rAddr", rAddr, 0);
        run_to(8);
        chk("first_frame_start", frame_start, 1);
        chk("first_de", de, 1);

        for (int i = 0; i < 6; i++) begin
            run_to(4 * (2 * tab[i].addr + 2) + 1);
            chk("tab_rgb_a", {red, green, blue}, tab[i].rgb);
            chk("tab_de_a", de, 1);
            run_to(4 * (2 * tab[i].addr + 3) + 1);
            chk("tab_rgb_b", {red, green, blue}, tab[i].rgb);
        end

        lows = 0;
        first_low = -1;
        while (cyc < 4 * 802) begin
            step();
            if (h_sync == 1'b0) begin
                lows++;
                if (first_low < 0) first_low = cyc;
            end
            if (cyc == 4 * 640) chk("line0_last_addr", rAddr, 319);
            if (cyc == 4 * 641) chk("blank_rAddr", rAddr, 0);
            if (cyc == 4 * 801) chk("line1_first_addr", rAddr, 0);
        end
        chk("hs_low_clocks", lows, 384);
        chk("hs_first_low", first_low, 4 * 658);

        run_to(4 * 1601);
        chk("line2_oe", oe, 1);
        chk("line2_first_addr", rAddr, 320);

        run_to(4 * (3 * 800 + 300) + 2);
        reset = 1'b1;
        step();
        check_reset_state();
        hold = int'($urandom_range(1, 3));
        repeat (hold) step();
        check_reset_state();
        reset = 1'b0;
        run_to(4);
        chk("restart_oe", oe, 1);
        chk("restart_rAddr", rAddr, 0);
        run_to(8);
        chk("restart_frame_start", frame_start, 1);
        chk("restart_rgb", {red, green, blue}, tab[0].rgb);
        run_to(4 * 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Display-side reader for the 320x240 RGB565 frame buffer. Generates 640x480@60 VGA timing from the system clock and drives the buffer's read port with 2x-upscaled addresses. Aligns sync and blanking with the buffer's one-cycle registered read latency and converts RGB565 to the board's 4:4:4 DAC. Sits between the frame buffer's read side (`rclk` = `clk`) and the VGA connector.

## Interface
Parameters:
- `CLK_DIV`, default 4: system clocks per pixel; 100 MHz / 4 = 25 MHz pixel rate. Must be ≥ 2.

Ports:
- `clk`  in  1: system clock; also drives the frame buffer `rclk`.
- `reset`  in  1: synchronous, active-high reset.
- `rAddr`  out  17: frame buffer read address, 0..76799.
- `oe`  out  1: frame buffer output enable. One-clock pulse per visible pixel.
- `rData`  in  16: frame buffer read data, RGB565. Valid one clock after `oe`.
- `h_sync`  out  1: horizontal sync, active low.
- `v_sync`  out  1: vertical sync, active low.
- `de`  out  1: display enable, high during visible pixels.
- `red`, `green`, `blue`  out  4 each: pixel colour.
- `frame_start`  out  1: one-clock pulse at the start of each frame.

## Operation
- **Pixel tick.**
  - Divider counts 0..CLK_DIV-1.
  - `tick` is high for one clock when the divider equals CLK_DIV-1.
  - All state below advances only on `tick`.
- **Counters.**
  - `h_cnt` runs 0..799.
  - `v_cnt` runs 0..524 and increments when `h_cnt` wraps from 799 to 0.
  - `v_cnt` wraps from 524 to 0.
- **Horizontal timing:** visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- **Vertical timing:** visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- **visible** = (`h_cnt` < 640) && (`v_cnt` < 480).
- **Address.** x = `h_cnt`>>1, y = `v_cnt`>>1, addr = (y<<8) + (y<<6) + x. The intermediate sum is 17 bits wide.
- **Stage 1**, loaded on a tick from the pre-advance counter values:
  - `rAddr` = visible ? addr : 0.
  - `oe` = visible; it is cleared on the following clock, so it is a single-clock pulse.
  - Delayed copies `de_p`, `hs_p`, `vs_p`.
- **Buffer read.** The frame buffer registers `rData` on the clock after `oe`. It holds that value until the next `oe`.
- **Stage 2**, loaded on the next tick:
  - `de` ← `de_p`, `h_sync` ← `hs_p`, `v_sync` ← `vs_p`.
  - Colour = `de_p` ? convert(`rData`) : 0.
- **Default conversion:** `red` = rData[15:12], `green` = rData[10:7], `blue` = rData[4:1].
- **frame_start** pulses for one clock on the tick where stage 2 loads the pixel for `h_cnt`=0, `v_cnt`=0.

## Timing
- **Reset values:**
  - Divider, `h_cnt`, `v_cnt`, `rAddr`, `oe`, `de`, colours and `frame_start` reset to 0.
  - `h_sync` and `v_sync` reset to 1.
  - Stage 1 resets to the blank/inactive state.
- **First tick** after reset deassertion occurs CLK_DIV clocks later.
- **Latency.** A counter value reaches the pins 2 ticks later. Syncs and `de` carry the same 2-tick delay, so the pins are mutually aligned.
- **Read window.** Data from `oe` at clock t is sampled at t + CLK_DIV ≥ t + 2, which always falls inside the valid window.
- **Address sequence.**
  - Every buffer address is read twice per line, on consecutive ticks.
  - Each buffer row is read on two consecutive lines.
- **Blanking.** During blanking: `oe` = 0, `rAddr` = 0, colours = 0.
- **Reset mid-frame.** Reset asserted at any clock returns all outputs to their reset values on the next edge. Timing restarts at `h_cnt`=0, `v_cnt`=0, with no partial pulses carried over.

## Configuration
- Macro: `FB_READER_GRAY_EN`.
- **With the macro defined**, convert() outputs luminance on all three channels:
  - Expand to 8 bits: r8 = {R5, R5[4:2]}, g8 = {G6, G6[5:4]}, b8 = {B5, B5[4:2]}.
  - y8 = (77·r8 + 150·g8 + 29·b8) >> 8, computed in 16-bit unsigned arithmetic.
  - `red` = `green` = `blue` = y8[7:4].
  - Pipeline latency is unchanged; the conversion is combinational into the stage 2 register.
- **Without the macro**, the direct bit-slice conversion above is used.

## Structure
- **Package `vga_pkg`:**
  - Constants: H_VISIBLE, H_FP, H_SYNC, H_BP, H_TOTAL, V_VISIBLE, V_FP, V_SYNC, V_BP, V_TOTAL.
  - Constants: FB_W = 320, FB_H = 240, FB_ADDR_W = 17.
  - Typedef `rgb444_t` (struct of three 4-bit channels).
- **Sub-module `vga_timing_gen`:** tick divider, `h_cnt`/`v_cnt` and raw visible/sync flags.
- **Top `vga_fb_reader`:** address generation, the two pipeline stages and conversion.

## Test plan
- **Reset:** hold `reset` for 5 clocks → all outputs at reset values; first `oe` pulse 4 clocks after release, with `rAddr` = 0.
- **Red pixel:** buffer model returns 16'hF800 for address 0 → first `de` pixel is `red`=F, `green`=0, `blue`=0. It appears 2 ticks after the counter reaches 0,0, coincident with `frame_start`.
- **Address sequence:** line 0 reads 0,0,1,1,…,319,319; line 1 repeats it; line 2 starts at 320; line 479 ends at 76799.
- **Sync widths and period:**
  - `h_sync` low for exactly 96 ticks, starting 656 ticks after line start (+2-tick offset).
  - `v_sync` low for 2 lines (490..491).
  - `frame_start` period = 800·525·4 = 1,680,000 clocks.
- **Blanking and mid-line reset:** `rData` forced to 16'hFFFF during blanking → colours stay 0. Reset asserted at `h_cnt`=300 → outputs reset next clock; next frame starts cleanly from 0,0.
- **Gray mode** (`FB_READER_GRAY_EN`): 16'hFFFF → F,F,F; 16'h07E0 → 9,9,9; 16'h0000 → 0,0,0.
